// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// UART transmitter fed by a small input FIFO. Words pushed on the byte side
// are serialised LSB first with a start bit, DATA_BITS data bits, an optional
// even/odd parity bit and STOP_BITS stop bits. Every bit lasts CLKS_PER_BIT
// cycles of CLOCK_50, timed by an internal baud counter (no derived clocks).
//
// Ports
//   CLOCK_50    in   system clock, everything on the rising edge
//   reset_n     in   synchronous active-low reset (aborts any frame in flight)
//   in_data     in   word to send, LSB goes out first
//   in_valid    in   in_data is offered this cycle
//   in_ready    out  FIFO has room (registered occupancy != FIFO_DEPTH)
//   tx          out  serial line, registered, idles high
//   busy        out  a frame is in progress or the FIFO holds words
//   fifo_count  out  current FIFO occupancy
//   dbg_state   out  transmitter FSM state (IDLE=0 START=1 DATA=2 PARITY=3 STOP=4)
//
// Handshake: a word is transferred on every rising edge where in_valid and
// in_ready are both high. in_ready depends only on registered occupancy, so
// a pop on the same edge never makes room for a push on that edge; the
// producer may hold in_valid high and in_data stable until it sees the
// transfer.
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          CLOCK_50,
    input  logic                          reset_n,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    dbg_state
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CW           = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // FIFO storage and pointers
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;

    // Transmitter
    state_t               r_state;
    logic [CNT_W-1:0]     r_baud_cnt;
    logic [3:0]           r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic                 r_tx;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_nonempty;
    logic                 w_baud_wrap;
    logic                 w_last_stop;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_parity;

    assign w_fifo_nonempty = (r_count != '0);
    assign in_ready        = (r_count != CW'(FIFO_DEPTH));
    assign w_push          = in_valid && in_ready;
    assign w_head          = r_mem[r_rd_ptr];

    // Parity is taken from the word as it leaves the FIFO, so later FIFO
    // writes cannot disturb the frame already being sent.
    assign w_head_parity   = (PARITY == 2) ? ~^w_head : ^w_head;

    assign w_baud_wrap     = (r_baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_last_stop     = (r_state == ST_STOP) && w_baud_wrap &&
                             (r_stop_idx == 1'(STOP_BITS - 1));

    // Pop from IDLE, or on the final stop-bit cycle so the next start bit
    // follows with no idle gap.
    assign w_pop           = w_fifo_nonempty &&
                             ((r_state == ST_IDLE) || w_last_stop);

    assign tx         = r_tx;
    assign busy       = (r_state != ST_IDLE) || w_fifo_nonempty;
    assign fifo_count = r_count;
    assign dbg_state  = r_state;

    // FIFO data array (contents need no reset; pointers define validity)
    always_ff @(posedge CLOCK_50) begin
        if (reset_n && w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Transmitter FSM with registered line output
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_tx       <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
        end else begin
            // The counter sits at zero in IDLE so a popped frame always
            // starts with a full-length start bit.
            if ((r_state == ST_IDLE) || w_baud_wrap) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift  <= w_head;
                        r_parity <= w_head_parity;
                        r_state  <= ST_START;
                        r_tx     <= 1'b0;
                    end else begin
                        r_tx     <= 1'b1;
                    end
                end

                ST_START: begin
                    if (w_baud_wrap) begin
                        r_state   <= ST_DATA;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                    end
                end

                ST_DATA: begin
                    if (w_baud_wrap) begin
                        if (r_bit_idx == 4'(DATA_BITS - 1)) begin
                            if (PARITY != 0) begin
                                r_state <= ST_PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state    <= ST_STOP;
                                r_stop_idx <= 1'b0;
                                r_tx       <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end

                ST_PARITY: begin
                    if (w_baud_wrap) begin
                        r_state    <= ST_STOP;
                        r_stop_idx <= 1'b0;
                        r_tx       <= 1'b1;
                    end
                end

                ST_STOP: begin
                    if (w_baud_wrap) begin
                        if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                            if (w_pop) begin
                                r_shift  <= w_head;
                                r_parity <= w_head_parity;
                                r_state  <= ST_START;
                                r_tx     <= 1'b0;
                            end else begin
                                r_state  <= ST_IDLE;
                                r_tx     <= 1'b1;
                            end
                        end else begin
                            r_stop_idx <= r_stop_idx + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Two transmitters share clock and reset: A is 8E1, B is 7O2, both with a
// 4-entry FIFO and 5 clocks per bit. A frame-level reference model (word
// queue plus position within the current frame) predicts tx, in_ready, busy
// and fifo_count on every cycle. Directed frames are also checked bit by bit
// against hand-derived parity bits and frame lengths.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CPB   = 5;
    localparam int DEPTH = 4;
    localparam int M_DB  [2] = '{8, 7};
    localparam int M_PAR [2] = '{1, 2};
    localparam int M_SB  [2] = '{1, 2};

    logic       clk;
    logic       reset_n;
    logic [7:0] in_data_a;
    logic       in_valid_a;
    logic       in_ready_a;
    logic       tx_a;
    logic       busy_a;
    logic [2:0] fifo_count_a;
    logic [2:0] dbg_state_a;
    logic [6:0] in_data_b;
    logic       in_valid_b;
    logic       in_ready_b;
    logic       tx_b;
    logic       busy_b;
    logic [2:0] fifo_count_b;
    logic [2:0] dbg_state_b;

    uart_tx_fifo #(
        .CLK_HZ(50_000_000), .BAUD_RATE(10_000_000), .DATA_BITS(8),
        .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dut_a (
        .CLOCK_50(clk), .reset_n(reset_n), .in_data(in_data_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .tx(tx_a),
        .busy(busy_a), .fifo_count(fifo_count_a), .dbg_state(dbg_state_a)
    );

    uart_tx_fifo #(
        .CLK_HZ(50_000_000), .BAUD_RATE(10_000_000), .DATA_BITS(7),
        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
    ) dut_b (
        .CLOCK_50(clk), .reset_n(reset_n), .in_data(in_data_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .tx(tx_b),
        .busy(busy_b), .fifo_count(fifo_count_b), .dbg_state(dbg_state_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_chk;
    int n_err;
    int cyc;

    logic [8:0] m_mem  [2][DEPTH];
    int         m_n    [2];
    bit         m_act  [2];
    int         m_pos  [2];
    logic [8:0] m_word [2];

    logic tx_s   [0:79];
    logic busy_s [0:79];

    typedef struct {
        int         inst;
        logic [8:0] word;
        logic       par;
        int         len;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int flen(input int i);
        return (1 + M_DB[i] + ((M_PAR[i] != 0) ? 1 : 0) + M_SB[i]) * CPB;
    endfunction

    function automatic logic line_bit(input int i, input logic [8:0] w, input int k);
        logic p;
        p = 1'b0;
        for (int j = 0; j < M_DB[i]; j++) p = p ^ w[j];
        if (k == 0) return 1'b0;
        if (k <= M_DB[i]) return w[k-1];
        if (M_PAR[i] != 0 && k == M_DB[i] + 1) return (M_PAR[i] == 1) ? p : ~p;
        return 1'b1;
    endfunction

    function automatic logic exp_tx(input int i);
        return m_act[i] ? line_bit(i, m_word[i], m_pos[i] / CPB) : 1'b1;
    endfunction

    task automatic model_step();
        logic       v [2];
        logic [8:0] d [2];
        bit         push;
        int         pre_n;
        v[0] = in_valid_a;
        v[1] = in_valid_b;
        d[0] = {1'b0, in_data_a};
        d[1] = {2'b00, in_data_b};
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_n[i]   = 0;
                m_act[i] = 1'b0;
                m_pos[i] = 0;
            end else begin
                pre_n = m_n[i];
                push  = v[i] && (pre_n < DEPTH);
                if (m_act[i]) begin
                    m_pos[i]++;
                    if (m_pos[i] == flen(i)) m_act[i] = 1'b0;
                end
                if (!m_act[i] && pre_n > 0) begin
                    m_word[i] = m_mem[i][0];
                    for (int j = 0; j < DEPTH - 1; j++) m_mem[i][j] = m_mem[i][j+1];
                    m_n[i]--;
                    m_act[i] = 1'b1;
                    m_pos[i] = 0;
                end
                if (push) begin
                    m_mem[i][m_n[i]] = d[i];
                    m_n[i]++;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("a_tx",    32'(tx_a),         32'(exp_tx(0)));
        check("a_ready", 32'(in_ready_a),   32'(m_n[0] < DEPTH));
        check("a_busy",  32'(busy_a),       32'(m_act[0] || m_n[0] > 0));
        check("a_count", 32'(fifo_count_a), 32'(m_n[0]));
        check("b_tx",    32'(tx_b),         32'(exp_tx(1)));
        check("b_ready", 32'(in_ready_b),   32'(m_n[1] < DEPTH));
        check("b_busy",  32'(busy_b),       32'(m_act[1] || m_n[1] > 0));
        check("b_count", 32'(fifo_count_b), 32'(m_n[1]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic set_in(input int i, input logic v, input logic [8:0] d);
        if (i == 0) begin
            in_valid_a = v;
            in_data_a  = d[7:0];
        end else begin
            in_valid_b = v;
            in_data_b  = d[6:0];
        end
    endtask

    function automatic logic get_tx(input int i);
        return (i == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic get_busy(input int i);
        return (i == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic [2:0] get_count(input int i);
        return (i == 0) ? fifo_count_a : fifo_count_b;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_a || busy_b) && n < 600) begin
            tick();
            n++;
        end
        check("wait_idle", 32'(busy_a || busy_b), 32'(0));
    endtask

    // Push one word on an idle transmitter and check the whole frame.
    task automatic run_frame(input int idx, input int i, input logic [8:0] word,
                             input logic par, input int len);
        logic       eb;
        logic [4:0] seen;
        wait_idle();
        set_in(i, 1'b1, word);
        tick();
        set_in(i, 1'b0, 9'h0);
        check($sformatf("f%0d_tx_at_push", idx), 32'(get_tx(i)), 32'(1));
        check($sformatf("f%0d_count_at_push", idx), 32'(get_count(i)), 32'(1));
        tick();
        for (int s = 0; s <= len; s++) begin
            tx_s[s]   = get_tx(i);
            busy_s[s] = get_busy(i);
            if (s < len) tick();
        end
        for (int k = 0; k < len / CPB; k++) begin
            if (k == 0)                eb = 1'b0;
            else if (k <= M_DB[i])     eb = word[k-1];
            else if (k == M_DB[i] + 1) eb = par;
            else                       eb = 1'b1;
            for (int j = 0; j < CPB; j++) seen[j] = tx_s[k*CPB + j];
            check($sformatf("f%0d_bit%0d", idx, k), 32'(seen), 32'({5{eb}}));
        end
        check($sformatf("f%0d_busy_last", idx), 32'(busy_s[len-1]), 32'(1));
        check($sformatf("f%0d_busy_end", idx),  32'(busy_s[len]),   32'(0));
        check($sformatf("f%0d_tx_end", idx),    32'(tx_s[len]),     32'(1));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int wait_n;
        int pct;

        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        for (int i = 0; i < 2; i++) begin
            m_n[i]    = 0;
            m_act[i]  = 1'b0;
            m_pos[i]  = 0;
            m_word[i] = '0;
        end

        // Hand-derived parity bits: 8E1 on A, 7O2 on B; both frames 11 bits.
        vecs[0] = '{inst: 0, word: 9'h0A5, par: 1'b0, len: 55};
        vecs[1] = '{inst: 0, word: 9'h007, par: 1'b1, len: 55};
        vecs[2] = '{inst: 0, word: 9'h0FF, par: 1'b0, len: 55};
        vecs[3] = '{inst: 1, word: 9'h007, par: 1'b0, len: 55};
        vecs[4] = '{inst: 1, word: 9'h000, par: 1'b1, len: 55};
        vecs[5] = '{inst: 1, word: 9'h07F, par: 1'b0, len: 55};

        // Reset held with in_valid high: nothing may be enqueued.
        reset_n = 1'b0;
        set_in(0, 1'b1, 9'h05A);
        set_in(1, 1'b1, 9'h033);
        for (int r = 0; r < 3; r++) begin
            tick();
            check("rst_a_tx",    32'(tx_a),         32'(1));
            check("rst_a_ready", 32'(in_ready_a),   32'(1));
            check("rst_a_busy",  32'(busy_a),       32'(0));
            check("rst_a_count", 32'(fifo_count_a), 32'(0));
            check("rst_a_state", 32'(dbg_state_a),  32'(0));
            check("rst_b_count", 32'(fifo_count_b), 32'(0));
            check("rst_b_state", 32'(dbg_state_b),  32'(0));
        end
        set_in(0, 1'b0, 9'h0);
        set_in(1, 1'b0, 9'h0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_a_count", 32'(fifo_count_a), 32'(0));
        check("post_rst_b_busy",  32'(busy_b),       32'(0));

        // Directed frames
        for (int v = 0; v < 6; v++) begin
            run_frame(v, vecs[v].inst, vecs[v].word, vecs[v].par, vecs[v].len);
        end

        // Full FIFO on A: 0x01 pops at once, 0x02..0x05 fill it, 0x06 refused.
        wait_idle();
        set_in(0, 1'b1, 9'h001); tick();
        set_in(0, 1'b1, 9'h002); tick();
        check("full_tx_start", 32'(tx_a),         32'(0));
        check("full_count1",   32'(fifo_count_a), 32'(1));
        set_in(0, 1'b1, 9'h003); tick();
        set_in(0, 1'b1, 9'h004); tick();
        set_in(0, 1'b1, 9'h005); tick();
        check("full_count4",   32'(fifo_count_a), 32'(4));
        check("full_ready0",   32'(in_ready_a),   32'(0));
        set_in(0, 1'b1, 9'h006); tick();
        check("full_refused",  32'(fifo_count_a), 32'(4));

        // Push held across the STOP-to-START pop edge: refused on that edge,
        // accepted on the next one.
        set_in(0, 1'b1, 9'h066);
        wait_n = 0;
        while (!in_ready_a && wait_n < 200) begin
            tick();
            wait_n++;
        end
        check("pop_ready_rise", 32'(in_ready_a),   32'(1));
        check("pop_count3",     32'(fifo_count_a), 32'(3));
        check("pop_next_start", 32'(tx_a),         32'(0));
        tick();
        set_in(0, 1'b0, 9'h0);
        check("pop_push_taken", 32'(fifo_count_a), 32'(4));
        check("pop_ready_low",  32'(in_ready_a),   32'(0));
        wait_idle();

        // Mid-frame reset during the 4th data bit of 0x3C, with 0x11 queued.
        set_in(0, 1'b1, 9'h03C); tick();
        set_in(0, 1'b1, 9'h011); tick();
        set_in(0, 1'b0, 9'h0);
        for (int s = 0; s < 22; s++) tick();
        check("mid_count1", 32'(fifo_count_a), 32'(1));
        reset_n = 1'b0;
        tick();
        check("mid_rst_tx",    32'(tx_a),         32'(1));
        check("mid_rst_count", 32'(fifo_count_a), 32'(0));
        check("mid_rst_busy",  32'(busy_a),       32'(0));
        check("mid_rst_ready", 32'(in_ready_a),   32'(1));
        reset_n = 1'b1;
        tick();
        run_frame(6, 0, 9'h081, 1'b0, 55);

        // Randomised traffic, occasional resets
        pct = 10;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) begin
                case ($urandom_range(0, 2))
                    0:       pct = 3;
                    1:       pct = 15;
                    default: pct = 70;
                endcase
            end
            set_in(0, ($urandom_range(0, 99) < pct), 9'($urandom_range(0, 255)));
            set_in(1, ($urandom_range(0, 99) < pct), 9'($urandom_range(0, 127)));
            reset_n = ($urandom_range(0, 1999) != 0);
            tick();
        end
        reset_n = 1'b1;
        set_in(0, 1'b0, 9'h0);
        set_in(1, 1'b0, 9'h0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
